// File: rtl/nibble_adder_pkg.sv
// nibble_adder_pkg: shared state encoding, slice width and index sizing for the serial adder
package nibble_adder_pkg;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   localparam int NIBBLE_W = 4;
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/nibble_add4.sv
// nibble_add4: combinational 4-bit ripple-carry slice built from full-adder cells
module nibble_add4 (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       ci,
   output logic [3:0] s,
   output logic       co
);
   logic [4:0] c;
   assign c[0] = ci;
   for (genvar i = 0; i < 4; i++) begin : g_fa
      assign s[i]   = a[i] ^ b[i] ^ c[i];
      assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
   end
   assign co = c[4];
endmodule

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: wide add done one nibble per clock through a single shared 4-bit slice
module nibble_serial_adder
   import nibble_adder_pkg::*;
#(
   parameter int NIBBLES = 4
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            in_valid,
   output logic                            in_ready,
   input  logic [NIBBLE_W*NIBBLES-1:0]     a,
   input  logic [NIBBLE_W*NIBBLES-1:0]     b,
   input  logic                            c_in,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic [NIBBLE_W*NIBBLES:0]       sum,
   output logic                            busy
);
   localparam int W  = NIBBLE_W * NIBBLES;
   localparam int IW = idx_width(NIBBLES);
   state_t        state_q, state_d;
   logic [W-1:0]  a_q, a_d, b_q, b_d, res_q, res_d;
   logic [W:0]    sum_q, sum_d;
   logic [IW-1:0] idx_q, idx_d;
   logic          carry_q, carry_d;
   logic [3:0]    slice_s;
   logic          slice_co;
   nibble_add4 u_slice (
      .a  (a_q[3:0]),
      .b  (b_q[3:0]),
      .ci (carry_q),
      .s  (slice_s),
      .co (slice_co)
   );
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      sum_d   = sum_q;
      idx_d   = idx_q;
      carry_d = carry_q;
      case (state_q)
         IDLE: if (in_valid) begin
            state_d = RUN;
            a_d     = a;
            b_d     = b;
            carry_d = c_in;
            idx_d   = '0;
         end
         RUN: begin
            a_d     = a_q >> NIBBLE_W;
            b_d     = b_q >> NIBBLE_W;
            // new nibble enters at the top so the LSB-first stream lands in place
            res_d   = W'({slice_s, res_q} >> NIBBLE_W);
            carry_d = slice_co;
            idx_d   = idx_q + 1'b1;
            if (idx_q == IW'(NIBBLES - 1)) begin
               state_d = DONE;
               sum_d   = {slice_co, res_d};
            end
         end
         DONE: if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         sum_q   <= '0;
         idx_q   <= '0;
         carry_q <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         sum_q   <= sum_d;
         idx_q   <= idx_d;
         carry_q <= carry_d;
      end
   end
   assign in_ready  = (state_q == IDLE) & ~rst;
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign sum       = sum_q;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb_nibble_serial_adder: directed checks of the serial nibble adder with NIBBLES=4
module tb_nibble_serial_adder;
   logic        clk = 1'b0;
   logic        rst, in_valid, out_ready, c_in;
   logic [15:0] a, b;
   logic        in_ready, out_valid, busy;
   logic [16:0] sum;
   int          total = 0;
   int          bad = 0;

   nibble_serial_adder #(.NIBBLES(4)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .c_in(c_in), .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_add(input string tag, input logic [15:0] av, input logic [15:0] bv,
                         input logic cv, input logic [16:0] exp);
      int cnt;
      cnt = 0;
      while (!in_ready && cnt < 20) begin
         step();
         cnt++;
      end
      chk({tag, "_ready"}, 32'(in_ready), 32'd1);
      a = av;
      b = bv;
      c_in = cv;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      a = 16'hDEAD;
      b = 16'hBEEF;
      c_in = 1'b1;
      cnt = 0;
      while (!out_valid && cnt < 20) begin
         chk({tag, "_busy"}, {30'd0, busy, in_ready}, 32'b10);
         step();
         cnt++;
      end
      chk({tag, "_lat"}, 32'(cnt), 32'd4);
      chk({tag, "_sum"}, 32'(sum), 32'(exp));
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk({tag, "_idle"}, {30'd0, out_valid, in_ready}, 32'b01);
   endtask

   initial begin
      int          cnt, cyc, last;
      logic        acc;
      logic [16:0] expv, pend;
      rst = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b0;
      a = '0;
      b = '0;
      c_in = 1'b0;
      step();
      chk("rst_outs", {28'd0, in_ready, out_valid, busy, 1'b0}, 32'd0);
      chk("rst_sum", 32'(sum), 32'd0);
      rst = 1'b0;
      #1;
      chk("post_rst_ready", {30'd0, in_ready, busy}, 32'b10);

      do_add("zero", 16'h0000, 16'h0000, 1'b0, 17'h00000);
      do_add("c8", 16'h00FF, 16'h0001, 1'b0, 17'h00100);
      do_add("ripple", 16'hFFFF, 16'h0001, 1'b0, 17'h10000);
      do_add("max", 16'hFFFF, 16'hFFFF, 1'b1, 17'h1FFFF);
      do_add("mix", 16'h1234, 16'h4321, 1'b0, 17'h05555);
      do_add("c12", 16'h0FFF, 16'h0001, 1'b0, 17'h01000);

      // backpressure: result must freeze while new offers are ignored
      a = 16'h1111;
      b = 16'h2222;
      c_in = 1'b0;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      cnt = 0;
      while (!out_valid && cnt < 20) begin
         step();
         cnt++;
      end
      chk("bp_sum0", 32'(sum), 32'h03333);
      for (int i = 0; i < 5; i++) begin
         in_valid = ~in_valid;
         a = 16'hAAAA + 16'(i);
         b = 16'h5555;
         c_in = 1'b1;
         step();
         chk("bp_hold", {13'd0, out_valid, in_ready, sum}, {13'd0, 1'b1, 1'b0, 17'h03333});
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("bp_release", {30'd0, out_valid, in_ready}, 32'b01);
      chk("bp_sum_held", 32'(sum), 32'h03333);
      do_add("after_bp", 16'h0101, 16'h0202, 1'b0, 17'h00303);

      // reset in the second RUN cycle aborts the add
      a = 16'h5555;
      b = 16'h5555;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      #1;
      chk("abort_state", {29'd0, out_valid, busy, in_ready}, 32'b001);
      chk("abort_sum", 32'(sum), 32'd0);
      for (int i = 0; i < 6; i++) begin
         step();
         chk("abort_noval", 32'(out_valid), 32'd0);
      end
      do_add("after_abort", 16'h0007, 16'h0009, 1'b0, 17'h00010);

      // back-to-back throughput with both handshakes held high
      last = -1;
      cyc = 0;
      pend = '0;
      a = 16'h8001;
      b = 16'h7FFF;
      c_in = 1'b1;
      in_valid = 1'b1;
      out_ready = 1'b1;
      for (int k = 0; k < 30; k++) begin
         acc = in_valid && in_ready;
         expv = {1'b0, a} + {1'b0, b} + 17'(c_in);
         step();
         cyc++;
         if (acc) begin
            if (last >= 0) chk("b2b_ii", 32'(cyc - last), 32'd6);
            last = cyc;
            pend = expv;
            a = 16'($urandom);
            b = 16'($urandom);
            c_in = 1'($urandom);
         end
         if (out_valid) chk("b2b_sum", 32'(sum), 32'(pend));
      end
      chk("b2b_seen", 32'(last > 0), 32'd1);
      in_valid = 1'b0;
      out_ready = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
